// File: rtl/key_4x4_emu_pkg.sv
// Shared types and helpers for the key_4x4 keypad emulator and its LFSR.
package key_4x4_emu_pkg;

  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

  // Press sequencer states; encoding is shared with other keypad models.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_B_IN  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_B_OUT = 3'd3,
    ST_GAP   = 3'd4
  } emu_state_e;

  // Key code layout {row[1:0], col[1:0]}, same as key_4x4 key_value.
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_code_t;

  // Largest of three phase lengths, used to size the phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Feedback bit for x^16+x^14+x^13+x^11+1 (taps 16,14,13,11).
  function automatic logic lfsr16_fb(input logic [LFSR_W-1:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

endpackage

// File: rtl/key_4x4_emu_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when step is high.
module key_lfsr16
  import key_4x4_emu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Shift in the feedback bit on each step; a nonzero seed never reaches zero.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr16_fb(lfsr_q)};
  end

  // LFSR state register, reloads the seed on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= seed;
    else      lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/key_4x4_emu.sv
// 4x4 matrix-keypad emulator: answers the column scan by pulling the
// pressed key's row low, one host-requested press at a time.
module key_4x4_emu
  import key_4x4_emu_pkg::*;
#(
  parameter int unsigned        BOUNCE_CYC = 250_000,
  parameter int unsigned        HOLD_CYC   = 1_000_000,
  parameter int unsigned        GAP_CYC    = 500_000,
  parameter int unsigned        TOGGLE_DIV = 2_500,
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COL_W-1:0] key_col_i,
  output logic [ROW_W-1:0] key_row_o,
  input  logic             req_valid,
  input  logic [KEY_W-1:0] req_key,
  input  logic             req_bounce,
  output logic             req_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(max3(BOUNCE_CYC, HOLD_CYC, GAP_CYC)) + 1;
  localparam int unsigned TOG_W = $clog2(TOGGLE_DIV) + 1;

  localparam logic [CNT_W-1:0] BOUNCE_MAX = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_MAX    = CNT_W'(GAP_CYC - 1);
  localparam logic [TOG_W-1:0] TOG_MAX    = TOG_W'(TOGGLE_DIV - 1);

  emu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOG_W-1:0]  tog_q, tog_d;
  key_code_t         key_q, key_d;
  logic              bounce_q, bounce_d;
  logic              contact_q, contact_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              phase_last;
  logic              tog_last;
  logic [CNT_W-1:0]  phase_max;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_unused;

  // Pseudo-random source for bounce decisions.
  key_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Only bit 0 drives contact; the remaining bits are state of the generator.
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:1];

  assign accept   = req_valid & ready_q;
  assign tog_last = (tog_q == TOG_MAX);

  // Last count of the current phase.
  always_comb begin
    phase_max = '0;
    unique case (state_q)
      ST_B_IN, ST_B_OUT: phase_max = BOUNCE_MAX;
      ST_HOLD:           phase_max = HOLD_MAX;
      ST_GAP:            phase_max = GAP_MAX;
      default:           phase_max = '0;
    endcase
  end

  assign phase_last = (cnt_q == phase_max);

  // State and all datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tog_q     <= '0;
      key_q     <= '0;
      bounce_q  <= 1'b0;
      contact_q <= 1'b0;
      row_q     <= '1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      key_q     <= key_d;
      bounce_q  <= bounce_d;
      contact_q <= contact_d;
      row_q     <= row_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Phase sequencing; counters restart on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    tog_d   = tog_last ? '0 : tog_q + TOG_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tog_d = '0;
        if (accept) state_d = req_bounce ? ST_B_IN : ST_HOLD;
      end
      ST_B_IN:  if (phase_last) state_d = ST_HOLD;
      ST_HOLD:  if (phase_last) state_d = bounce_q ? ST_B_OUT : ST_GAP;
      ST_B_OUT: if (phase_last) state_d = ST_GAP;
      ST_GAP:   if (phase_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      tog_d = '0;
    end
  end

  // Contact bit, request capture, handshake flags and row return.
  always_comb begin
    key_d     = key_q;
    bounce_d  = bounce_q;
    contact_d = contact_q;
    lfsr_step = 1'b0;
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_GAP) && (state_d == ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        contact_d = 1'b0;
        if (accept) begin
          key_d     = key_code_t'(req_key);
          bounce_d  = req_bounce;
          // Without bounce the contact closes together with entering HOLD.
          contact_d = ~req_bounce;
        end
      end
      ST_B_IN, ST_B_OUT: begin
        // Phase exit wins over a decision falling on the same cycle.
        if (phase_last) begin
          contact_d = (state_q == ST_B_IN);
        end else if (tog_last) begin
          contact_d = lfsr_q[0];
          lfsr_step = 1'b1;
        end
      end
      ST_HOLD:  contact_d = ~(phase_last & ~bounce_q);
      ST_GAP:   contact_d = 1'b0;
      default:  contact_d = 1'b0;
    endcase

    // Only the latched column is inspected, even if several are low.
    row_d = '1;
    if (contact_q && !key_col_i[key_q.col]) row_d[key_q.row] = 1'b0;
  end

  assign key_row_o = row_q;
  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_4x4_emu.sv
// Randomized self-checking bench for key_4x4_emu against a phase-level model.
module tb_key_4x4_emu;

  localparam int unsigned BOUNCE = 20;
  localparam int unsigned HOLD   = 100;
  localparam int unsigned GAP    = 30;
  localparam int unsigned DIV    = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_col_i;
  logic [3:0] key_row_o;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_bounce;
  logic       req_ready;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  key_4x4_emu #(
    .BOUNCE_CYC (BOUNCE),
    .HOLD_CYC   (HOLD),
    .GAP_CYC    (GAP),
    .TOGGLE_DIV (DIV),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_col_i  (key_col_i),
    .key_row_o  (key_row_o),
    .req_valid  (req_valid),
    .req_key    (req_key),
    .req_bounce (req_bounce),
    .req_ready  (req_ready),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Row seen by the scanner for a given contact state and column drive.
  function automatic logic [3:0] row_expect(input int key, input logic c, input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    if (c && !col[key % 4]) r[key / 4] = 1'b0;
    return r;
  endfunction

  // Column drive: 0 fixed, 1 one-hot-low scan, 2 arbitrary random.
  function automatic logic [3:0] col_pick(input int mode, input int t, input logic [3:0] fixed);
    logic [3:0] v;
    v = 4'b0001;
    if (mode == 0) return fixed;
    if (mode == 1) begin
      v = v << (t % 4);
      return ~v;
    end
    return 4'($urandom_range(0, 15));
  endfunction

  // Idle cycles: row released, ready, not busy, no done.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_vec++;
      if (key_row_o !== 4'hF || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL idle row=%b ready=%b busy=%b done=%b want row=1111 ready=1 busy=0 done=0",
                 key_row_o, req_ready, busy, done);
      end
      key_col_i = 4'($urandom_range(0, 15));
      req_valid = 1'b0;
    end
  endtask

  // One press: builds the expected contact timeline, then checks every cycle.
  task automatic run_press(input int key, input logic bnc, input int mode,
                           input logic [3:0] fixed, input bit noise, input int abort_at);
    logic       exp_c[$];
    logic       cur;
    logic       c_prev;
    logic [3:0] col_prev;
    logic [3:0] exp_row;
    int         total;

    exp_c.delete();
    cur = ~bnc;
    for (int p = 0; p < 2; p++) begin
      if (bnc) begin
        for (int i = 0; i < int'(BOUNCE); i++) begin
          exp_c.push_back(cur);
          if (i == int'(BOUNCE) - 1) cur = (p == 0);
          else if (i % int'(DIV) == int'(DIV) - 1) begin
            cur    = m_lfsr[0];
            m_lfsr = lfsr_next(m_lfsr);
          end
        end
      end
      if (p == 0) for (int i = 0; i < int'(HOLD); i++) exp_c.push_back(1'b1);
    end
    for (int i = 0; i < int'(GAP); i++) exp_c.push_back(1'b0);
    total = exp_c.size();

    req_valid  = 1'b1;
    req_key    = 4'(key);
    req_bounce = bnc;
    key_col_i  = col_pick(mode, 0, fixed);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_ready key=%0d ready=%b want 1", key, req_ready);
    end
    c_prev   = 1'b0;
    col_prev = key_col_i;
    @(posedge clk);

    for (int t = 0; t <= total; t++) begin
      @(negedge clk);
      exp_row = row_expect(key, c_prev, col_prev);
      n_vec++;
      if (key_row_o !== exp_row) begin
        n_err++;
        $display("FAIL row key=%0d bnc=%b t=%0d got=%b want=%b", key, bnc, t, key_row_o, exp_row);
      end
      n_vec++;
      if (done !== (t == total)) begin
        n_err++;
        $display("FAIL done key=%0d t=%0d got=%b want=%b", key, t, done, (t == total));
      end
      n_vec++;
      if (busy !== (t < total)) begin
        n_err++;
        $display("FAIL busy key=%0d t=%0d got=%b want=%b", key, t, busy, (t < total));
      end
      n_vec++;
      if (req_ready !== (t == total)) begin
        n_err++;
        $display("FAIL ready key=%0d t=%0d got=%b want=%b", key, t, req_ready, (t == total));
      end

      if (t == abort_at) begin
        rst = 1'b0;
        #1;
        n_vec++;
        if (key_row_o !== 4'hF || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
          n_err++;
          $display("FAIL abort_reset row=%b ready=%b busy=%b done=%b want 1111/1/0/0",
                   key_row_o, req_ready, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
          key_col_i = 4'($urandom_range(0, 15));
          @(negedge clk);
          n_vec++;
          if (key_row_o !== 4'hF || done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_hold row=%b done=%b busy=%b want 1111/0/0", key_row_o, done, busy);
          end
        end
        rst      = 1'b1;
        req_valid = 1'b0;
        m_lfsr   = SEED;
        return;
      end

      if (t < total) begin
        key_col_i  = col_pick(mode, t + 1, fixed);
        req_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        req_key    = 4'($urandom_range(0, 15));
        req_bounce = 1'($urandom_range(0, 1));
        c_prev     = exp_c[t];
        col_prev   = key_col_i;
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_vec++;
      if (key_row_o !== 4'hF || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL reset row=%b ready=%b busy=%b done=%b want 1111/1/0/0",
                 key_row_o, req_ready, busy, done);
      end
      key_col_i = 4'($urandom_range(0, 15));
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    req_valid = 1'b0;
    rst       = 1'b1;
    m_lfsr    = SEED;
    idle(2);
  endtask

  task automatic test_no_bounce();
    run_press(6, 1'b0, 0, 4'b1011, 1'b0, -1);
    idle(2);
  endtask

  task automatic test_col_scan();
    run_press(6, 1'b0, 1, 4'hF, 1'b0, -1);
    idle(1);
  endtask

  task automatic test_bounce();
    run_press(15, 1'b1, 0, 4'b0111, 1'b0, -1);
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_press($urandom_range(0, 15), 1'($urandom_range(0, 1)), 2, 4'hF, 1'b1, -1);
    run_press($urandom_range(0, 15), 1'b1, 1, 4'hF, 1'b1, -1);
    idle(1);
  endtask

  task automatic test_reset_mid_hold();
    run_press(9, 1'b0, 0, 4'b1101, 1'b0, 50);
    idle(1);
    run_press(9, 1'b0, 0, 4'b1101, 1'b0, -1);
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_press($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);
      idle($urandom_range(0, 3));
    end
  endtask

  task automatic test_all_keys();
    for (int k = 0; k < 16; k++) begin
      run_press(k, 1'($urandom_range(0, 1)), 1, 4'hF, 1'b0, -1);
    end
    idle(2);
  endtask

  initial begin
    rst        = 1'b0;
    key_col_i  = 4'hF;
    req_valid  = 1'b0;
    req_key    = 4'h0;
    req_bounce = 1'b0;
    m_lfsr     = SEED;
    @(negedge clk);
    test_reset();
    test_no_bounce();
    test_col_scan();
    test_bounce();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    test_all_keys();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t, bench did not complete", $time);
    $fatal(1, "watchdog");
  end

endmodule
